// File: rtl/alu_vect_pkg.sv
// Shared definitions for the lane-parallel vector ALU: opcode encodings
// carried on ctrl and the bit positions inside the flags output.
package alu_vect_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_SRL = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_AND = 4'b0110,
    OP_OR  = 4'b0111,
    OP_XOR = 4'b1000
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_lane.sv
// One combinational ALU lane: N-bit result plus the lane's carry and
// overflow contributions, which the top ORs across all lanes.
module alu_lane
  import alu_vect_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_e      op,
  output logic [N-1:0] y,
  output logic         c,
  output logic         v
);

  logic [N:0]            sum_ext;
  logic [N:0]            diff_ext;
  logic signed [2*N-1:0] prod;

  // Shifts rely on the language rule that amounts >= N shift every bit out,
  // which yields zero for >>/<< and sign fill for >>> on a signed operand.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    prod     = $signed(a) * $signed(b);
    y        = '0;
    c        = 1'b0;
    v        = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum_ext[N-1:0];
        c = sum_ext[N];
        v = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
      end
      OP_SUB: begin
        y = diff_ext[N-1:0];
        c = ~diff_ext[N];
        v = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
      end
      OP_MUL: begin
        y = prod[N-1:0];
        v = (prod != {{N{prod[N-1]}}, prod[N-1:0]});
      end
      OP_SRL: y = a >> b;
      OP_SLL: y = a << b;
      OP_SRA: y = $signed(a) >>> b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      default: begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_vect_2.sv
// Vector ALU top: M parallel lanes, flag reduction across lanes and the
// single output register stage giving one-cycle latency.
module alu_vect_2
  import alu_vect_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [0:M-1][N-1:0] a,
  input  logic signed [0:M-1][N-1:0] b,
  input  logic [3:0]                ctrl,
  output logic signed [0:M-1][N-1:0] result,
  output logic [3:0]                flags
);

  alu_op_e                   op;
  logic [0:M-1][N-1:0]        lane_y;
  logic [M-1:0]              lane_c;
  logic [M-1:0]              lane_v;
  logic [M-1:0]              lane_msb;
  logic signed [0:M-1][N-1:0] result_d;
  logic signed [0:M-1][N-1:0] result_q;
  logic [3:0]                flags_d;
  logic [3:0]                flags_q;

  // Unused ctrl codes fall through to the lanes' default arm (zero result).
  assign op = alu_op_e'(ctrl);

  for (genvar i = 0; i < M; i++) begin : g_lane
    alu_lane #(
      .N (N)
    ) u_lane (
      .a  (a[i]),
      .b  (b[i]),
      .op (op),
      .y  (lane_y[i]),
      .c  (lane_c[i]),
      .v  (lane_v[i])
    );
    assign lane_msb[i] = lane_y[i][N-1];
  end

  always_comb begin
    result_d         = lane_y;
    flags_d          = '0;
    flags_d[FLAG_N]  = |lane_msb;
    flags_d[FLAG_Z]  = (lane_y == '0);
    flags_d[FLAG_C]  = |lane_c;
    flags_d[FLAG_V]  = |lane_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_vect_2.sv
// Directed and randomized checks of alu_vect_2 against an integer-arithmetic
// reference model of the lane operations and flag rules.
module tb_alu_vect_2;

  localparam int N = 8;
  localparam int M = 4;

  typedef logic [0:M-1][N-1:0] vec_t;

  logic       clk;
  logic       rst_n;
  vec_t       a_in;
  vec_t       b_in;
  logic [3:0] ctrl;
  vec_t       result;
  logic [3:0] flags;

  int testCount = 0;
  int failCount = 0;

  vec_t       exp_r;
  logic [3:0] exp_f;
  vec_t       ra;
  vec_t       rb;
  logic [3:0] rc;

  alu_vect_2 #(
    .N (N),
    .M (M)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a_in),
    .b      (b_in),
    .ctrl   (ctrl),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t pack(input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    int   e[4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < M; i++) v[i] = e[i][N-1:0];
    return v;
  endfunction

  function automatic bit outOfRange(input longint x);
    return (x > (longint'(1) << (N - 1)) - 1) || (x < -(longint'(1) << (N - 1)));
  endfunction

  function automatic longint floorDiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: each lane computed with unbounded integers, then reduced mod 2**N.
  function automatic void refModel(input vec_t av, input vec_t bv, input logic [3:0] op,
                                   output vec_t rv, output logic [3:0] fv);
    longint modN;
    longint ua, ub, sa, sb, full, lo;
    bit     anyC, anyV, anyNeg, allZero;
    modN    = longint'(1) << N;
    anyC    = 0;
    anyV    = 0;
    anyNeg  = 0;
    allZero = 1;
    rv      = '0;
    for (int i = 0; i < M; i++) begin
      ua   = longint'(av[i]);
      ub   = longint'(bv[i]);
      sa   = (ua >= modN / 2) ? ua - modN : ua;
      sb   = (ub >= modN / 2) ? ub - modN : ub;
      full = 0;
      case (op)
        4'd0: begin full = sa + sb; anyC |= (ua + ub >= modN); anyV |= outOfRange(full); end
        4'd1: begin full = sa - sb; anyC |= (ua >= ub);        anyV |= outOfRange(full); end
        4'd2: begin full = sa * sb; anyV |= outOfRange(full); end
        4'd3: full = (ub >= N) ? 0 : ua / (longint'(1) << ub);
        4'd4: full = (ub >= N) ? 0 : ua * (longint'(1) << ub);
        4'd5: full = (ub >= N) ? ((sa < 0) ? -1 : 0) : floorDiv(sa, longint'(1) << ub);
        4'd6: full = ua & ub;
        4'd7: full = ua | ub;
        4'd8: full = ua ^ ub;
        default: full = 0;
      endcase
      lo = ((full % modN) + modN) % modN;
      rv[i] = lo[N-1:0];
      if (lo >= modN / 2) anyNeg = 1;
      if (lo != 0) allZero = 0;
    end
    fv = {anyNeg, allZero, anyC, anyV};
  endfunction

  task automatic applyStimulus(input vec_t av, input vec_t bv, input logic [3:0] op);
    @(negedge clk);
    a_in = av;
    b_in = bv;
    ctrl = op;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t er, input logic [3:0] ef);
    testCount++;
    assert (result === er) else begin
      failCount++;
      $error("[TB] FAIL %s result observed=%h expected=%h", tag, result, er);
    end
    testCount++;
    assert (flags === ef) else begin
      failCount++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", tag, flags, ef);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in  = '0;
    b_in  = '0;
    ctrl  = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", '0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(pack(5, -3, 100, -128), pack(3, 2, 2, 1), 4'b0010);
    checkOutput("mul_vec", pack(15, -6, -56, -128), 4'b1001);
    applyStimulus(pack(5, -3, 100, -128), pack(3, 2, 2, 1), 4'b0011);
    checkOutput("srl_vec", pack(0, 63, 25, 64), 4'b0000);
    applyStimulus(pack(5, -3, 100, -128), pack(3, 2, 2, 1), 4'b0100);
    checkOutput("sll_vec", pack(40, -12, -112, 0), 4'b1000);
    applyStimulus(pack(5, -3, 100, -128), pack(3, 2, 2, 1), 4'b0101);
    checkOutput("sra_vec", pack(0, -1, 25, -64), 4'b1000);
    applyStimulus(pack(127, 0, 0, 0), pack(1, 0, 0, 0), 4'b0000);
    checkOutput("add_ovf", pack(-128, 0, 0, 0), 4'b1001);
    applyStimulus(pack(127, 0, 0, 0), pack(1, 0, 0, 0), 4'b1111);
    checkOutput("bad_op", '0, 4'b0100);
    applyStimulus(pack(-1, 0, 0, 0), pack(1, 0, 0, 0), 4'b0000);
    checkOutput("add_carry", '0, 4'b0110);
    applyStimulus(pack(-128, 5, 0, 0), pack(-128, 5, 0, 0), 4'b0001);
    checkOutput("sub_equal", '0, 4'b0110);
    applyStimulus(pack(-128, 0, 0, 0), pack(1, 0, 0, 0), 4'b0001);
    checkOutput("sub_ovf", pack(127, 0, 0, 0), 4'b0011);
    applyStimulus(pack(1, 1, 1, 1), pack(2, 2, 2, 2), 4'b0001);
    checkOutput("sub_borrow", pack(-1, -1, -1, -1), 4'b1000);
    applyStimulus(pack(-128, 64, -1, 1), pack(8, 200, 8, 7), 4'b0101);
    checkOutput("sra_big", pack(-1, 0, -1, 0), 4'b1000);
    applyStimulus(pack(-128, 64, -1, 1), pack(8, 200, 7, 7), 4'b0011);
    checkOutput("srl_big", pack(0, 0, 1, 0), 4'b0000);
    applyStimulus(pack(1, 1, 1, -1), pack(7, 8, 255, 0), 4'b0100);
    checkOutput("sll_big", pack(-128, 0, 0, -1), 4'b1000);
    applyStimulus(pack(12, 10, -1, 0), pack(10, 6, 5, -1), 4'b0110);
    checkOutput("and_vec", pack(8, 2, 5, 0), 4'b0000);
    applyStimulus(pack(12, 10, -1, 0), pack(10, 6, 5, -1), 4'b0111);
    checkOutput("or_vec", pack(14, 14, -1, -1), 4'b1000);
    applyStimulus(pack(12, 10, -1, 0), pack(10, 6, 5, -1), 4'b1000);
    checkOutput("xor_vec", pack(6, 12, -6, -1), 4'b1000);

    // Asynchronous reset while a non-zero result is held, then release.
    applyStimulus(pack(5, -3, 100, -128), pack(3, 2, 2, 1), 4'b0010);
    checkOutput("pre_rst", pack(15, -6, -56, -128), 4'b1001);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", '0, 4'b0000);
    a_in = pack(127, 0, 0, 0);
    b_in = pack(1, 0, 0, 0);
    ctrl = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("rst_hold", '0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_release", pack(-128, 0, 0, 0), 4'b1001);

    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < M; i++) begin
        ra[i] = N'($urandom);
        rb[i] = ($urandom_range(0, 1) == 1) ? N'($urandom_range(0, 11)) : N'($urandom);
      end
      rc = 4'($urandom_range(0, 15));
      applyStimulus(ra, rb, rc);
      refModel(ra, rb, rc, exp_r, exp_f);
      checkOutput($sformatf("rand%0d_op%0d", k, rc), exp_r, exp_f);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
